reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement buffer feeding the register file. Decoder allocates one entry per instr and gets a tag.
//  Tags are used to rename rd in regfile. Execution units write results back by tag over the CDB.
//  Head entries retire in order as commit writes to regfile. A mispredicted branch at head raises clear for the whole core.
// PARAMETERS
//  ROB_SIZE   16  number of entries (power of 2)
//  IDX_W      4   log2(ROB_SIZE)
//  TAG_W      5   tag width; tag = entry index + 1, tag 0 = empty tag (no producer)
//  DATA_W     32  result / pc width
//  REG_W      5   architectural register index width; reg 0 = empty reg (no write)
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst           in   1       synchronous reset, ACTIVE-LOW (rst==0 resets)
//  rdy           in   1       global ready; 0 freezes all state and outputs
//  alloc_valid   in   1       decoder requests one entry this cycle
//  alloc_dest    in   REG_W   rd of allocated instr (0 = none)
//  alloc_tag     out  TAG_W   comb: tag the next alloc receives (tail+1); drive to regfile tag_rename
//  rob_full      out  1       comb: count==ROB_SIZE; decoder must not alloc
//  cdb_valid     in   1       result broadcast valid
//  cdb_tag       in   TAG_W   producer tag of broadcast
//  cdb_data      in   DATA_W  result value
//  cdb_mispred   in   1       broadcast is a branch that mispredicted
//  cdb_target    in   DATA_W  correct pc when cdb_mispred
//  query_tag1    in   TAG_W   decoder operand-1 tag from regfile
//  query_ready1  out  1       comb: entry ready, or CDB hitting query_tag1 this cycle
//  query_data1   out  DATA_W  comb: entry value, CDB data when bypassing
//  query_tag2/query_ready2/query_data2   as above for operand 2
//  if_commit     out  1       reg: one entry retired; regfile write strobe
//  pos_commit    out  REG_W   reg: rd of retired entry
//  data_commit   out  DATA_W  reg: value of retired entry
//  tag_commit    out  TAG_W   reg: tag of retired entry (regfile clears rename only if matching)
//  clear         out  1       reg: one-cycle core flush pulse
//  clear_pc      out  DATA_W  reg: redirect pc, valid while clear==1
// BEHAVIOUR
//  - Reset (rst==0 at posedge): head=tail=count=0, all entries invalid/not-ready.
//    if_commit=0, pos_commit=0, data_commit=0, tag_commit=0, clear=0, clear_pc=0.
//  - rdy==0: nothing changes, registered outputs hold their values (no duplicate or lost commit).
//  - Entry fields: valid, ready, dest, data, mispred, target.
//  - Alloc: alloc_valid && !rob_full -> entry[tail] = {valid,!ready,alloc_dest}; tail+=1 mod ROB_SIZE (wraps 15->0).
//    alloc_valid while full is ignored; no state changes.
//  - Writeback: cdb_valid && cdb_tag!=0 && entry[cdb_tag-1].valid -> ready=1 and store data/mispred/target.
//    Writebacks to invalid entries are dropped.
//  - Commit: count>0 && entry[head].ready -> next cycle if_commit=1 with that entry's dest/data/tag=head+1.
//    Entry invalidated, head+=1. Otherwise if_commit=0. Max one commit per cycle.
//  - Latency: CDB write in cycle N -> earliest if_commit high in cycle N+1 registered window (no CDB->commit bypass).
//  - count update: +1 on alloc, -1 on commit, unchanged when both fire in the same cycle.
//    Full is evaluated on the pre-edge count.
//  - Mispredict: committing entry has mispred=1 -> its commit is still emitted (jal/jalr rd written).
//    Same edge: clear=1, clear_pc=target, all entries invalid, head=tail=count=0.
//    Alloc in the same cycle is discarded. clear deasserts next active cycle.
//  - Query: tag 0 -> ready=1, data=0. Invalid entry -> ready=0.
//    CDB with matching tag same cycle -> ready=1, data=cdb_data.
// TESTING
//  1. rst=0 for 2 cycles with alloc_valid=1 -> count stays 0, if_commit=0, clear=0, alloc_tag=1.
//  2. Alloc x1,x2,x3 (tags 1,2,3); CDB tag3=0x33, tag1=0x11, tag2=0x22 -> commits x1=0x11, x2=0x22, x3=0x33 on consecutive cycles.
//  3. Alloc 16 with no writeback -> rob_full=1; 17th alloc ignored (alloc_tag stays 1).
//     Complete tag 1 -> commit, next alloc gets tag 1 (wrap).
//  4. Alloc tags 1..4; CDB tag 2 mispred target 0x100 after tag 1 done -> commits tag1, tag2, clear=1, clear_pc=0x100.
//     Tags 3,4 never commit; next alloc_tag=1.
//  5. Commit pending, rdy=0 for 3 cycles -> if_commit/pos_commit hold, head unchanged; rdy=1 -> single commit observed.
//  6. query_tag1=5 with CDB tag5=0xAB same cycle -> query_ready1=1, query_data1=0xAB; query_tag1=0 -> ready=1, data=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates tagged entries, captures CDB
// results by tag, and retires one ready head entry per cycle into the regfile.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispred,
  input  logic [DATA_W-1:0] cdb_target,
  input  logic [TAG_W-1:0]  query_tag1,
  output logic              query_ready1,
  output logic [DATA_W-1:0] query_data1,
  input  logic [TAG_W-1:0]  query_tag2,
  output logic              query_ready2,
  output logic [DATA_W-1:0] query_data2,
  output logic              if_commit,
  output logic [REG_W-1:0]  pos_commit,
  output logic [DATA_W-1:0] data_commit,
  output logic [TAG_W-1:0]  tag_commit,
  output logic              clear,
  output logic [DATA_W-1:0] clear_pc
);

  logic [ROB_SIZE-1:0] valid_q, valid_d, ready_q, ready_d, mispred_q, mispred_d;
  logic [REG_W-1:0]    dest_q   [ROB_SIZE];
  logic [REG_W-1:0]    dest_d   [ROB_SIZE];
  logic [DATA_W-1:0]   data_q   [ROB_SIZE];
  logic [DATA_W-1:0]   data_d   [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];
  logic [DATA_W-1:0]   target_d [ROB_SIZE];
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]      count_q, count_d;

  logic                if_commit_q, if_commit_d, clear_q, clear_d;
  logic [REG_W-1:0]    pos_commit_q, pos_commit_d;
  logic [DATA_W-1:0]   data_commit_q, data_commit_d, clear_pc_q, clear_pc_d;
  logic [TAG_W-1:0]    tag_commit_q, tag_commit_d;

  logic                do_alloc, do_commit, do_wb;
  logic [IDX_W-1:0]    wb_idx;

  assign alloc_tag   = TAG_W'(tail_q) + TAG_W'(1);
  assign rob_full    = (count_q == (IDX_W+1)'(ROB_SIZE));
  assign wb_idx      = IDX_W'(cdb_tag - TAG_W'(1));
  assign do_wb       = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SIZE))
                       && valid_q[wb_idx];
  assign do_alloc    = alloc_valid && !rob_full;
  assign do_commit   = (count_q != '0) && valid_q[head_q] && ready_q[head_q];

  assign if_commit   = if_commit_q;
  assign pos_commit  = pos_commit_q;
  assign data_commit = data_commit_q;
  assign tag_commit  = tag_commit_q;
  assign clear       = clear_q;
  assign clear_pc    = clear_pc_q;

  // Operand lookup: empty tag is always ready, a same-cycle CDB hit bypasses the entry.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
    logic [IDX_W-1:0] idx;
    idx    = IDX_W'(tag - TAG_W'(1));
    lookup = '0;
    if (tag == '0)
      lookup = {1'b1, {DATA_W{1'b0}}};
    else if (cdb_valid && (cdb_tag == tag))
      lookup = {1'b1, cdb_data};
    else if ((tag <= TAG_W'(ROB_SIZE)) && valid_q[idx])
      lookup = {ready_q[idx], data_q[idx]};
  endfunction

  always_comb begin
    {query_ready1, query_data1} = lookup(query_tag1);
    {query_ready2, query_data2} = lookup(query_tag2);
  end

  always_comb begin
    valid_d       = valid_q;
    ready_d       = ready_q;
    mispred_d     = mispred_q;
    dest_d        = dest_q;
    data_d        = data_q;
    target_d      = target_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if_commit_d   = 1'b0;
    pos_commit_d  = pos_commit_q;
    data_commit_d = data_commit_q;
    tag_commit_d  = tag_commit_q;
    clear_d       = 1'b0;
    clear_pc_d    = clear_pc_q;

    if (do_wb) begin
      ready_d[wb_idx]   = 1'b1;
      data_d[wb_idx]    = cdb_data;
      mispred_d[wb_idx] = cdb_mispred;
      target_d[wb_idx]  = cdb_target;
    end

    if (do_commit) begin
      if_commit_d     = 1'b1;
      pos_commit_d    = dest_q[head_q];
      data_commit_d   = data_q[head_q];
      tag_commit_d    = TAG_W'(head_q) + TAG_W'(1);
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end

    if (do_alloc) begin
      valid_d[tail_q]   = 1'b1;
      ready_d[tail_q]   = 1'b0;
      mispred_d[tail_q] = 1'b0;
      dest_d[tail_q]    = alloc_dest;
      tail_d            = tail_q + IDX_W'(1);
    end

    case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + (IDX_W+1)'(1);
      2'b01:   count_d = count_q - (IDX_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Mispredicted head still retires, then the flush overrides any alloc this cycle.
    if (do_commit && mispred_q[head_q]) begin
      clear_d    = 1'b1;
      clear_pc_d = target_q[head_q];
      valid_d    = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q       <= '0;
      ready_q       <= '0;
      mispred_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      if_commit_q   <= 1'b0;
      pos_commit_q  <= '0;
      data_commit_q <= '0;
      tag_commit_q  <= '0;
      clear_q       <= 1'b0;
      clear_pc_q    <= '0;
    end else if (rdy) begin
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      mispred_q     <= mispred_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      if_commit_q   <= if_commit_d;
      pos_commit_q  <= pos_commit_d;
      data_commit_q <= data_commit_d;
      tag_commit_q  <= tag_commit_d;
      clear_q       <= clear_d;
      clear_pc_q    <= clear_pc_d;
    end
  end

  // Payload storage needs no reset: entry valid/ready bits gate every use.
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      dest_q   <= dest_d;
      data_q   <= data_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits/flushes are queued at
// stimulus time and checked by a monitor as the DUT retires entries.
module tb_reorder_buffer;

  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned EXP_W    = REG_W + DATA_W + TAG_W;

  logic              clk = 1'b0;
  logic              rst, rdy;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic [TAG_W-1:0]  alloc_tag;
  logic              rob_full;
  logic              cdb_valid, cdb_mispred;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data, cdb_target;
  logic [TAG_W-1:0]  query_tag1, query_tag2;
  logic              query_ready1, query_ready2;
  logic [DATA_W-1:0] query_data1, query_data2;
  logic              if_commit, clear;
  logic [REG_W-1:0]  pos_commit;
  logic [DATA_W-1:0] data_commit, clear_pc;
  logic [TAG_W-1:0]  tag_commit;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic mon_rst, mon_rdy;
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] exp_clr_q[$];
  int commit_edges[$];

  always #5 clk = ~clk;

  reorder_buffer #(
    .ROB_SIZE(ROB_SIZE), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_tag(alloc_tag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
    .query_tag1(query_tag1), .query_ready1(query_ready1), .query_data1(query_data1),
    .query_tag2(query_tag2), .query_ready2(query_ready2), .query_data2(query_data2),
    .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
    .tag_commit(tag_commit), .clear(clear), .clear_pc(clear_pc)
  );

  // Retirement monitor: only edges taken out of reset with rdy=1 produce new output.
  always @(posedge clk) begin
    logic [EXP_W-1:0]  e;
    logic [DATA_W-1:0] pc;
    cyc = cyc + 1;
    mon_rst = rst;
    mon_rdy = rdy;
    #2;
    if (mon_rst && mon_rdy) begin
      if (if_commit) begin
        commit_edges.push_back(cyc);
        total_cnt++;
        if (exp_q.size() == 0)
          $display("FAIL commit_unexpected: got dest=%0d data=%0h tag=%0d required no commit",
                   pos_commit, data_commit, tag_commit);
        else begin
          e = exp_q.pop_front();
          if ({pos_commit, data_commit, tag_commit} !== e)
            $display("FAIL commit: got dest=%0d data=%0h tag=%0d required dest=%0d data=%0h tag=%0d",
                     pos_commit, data_commit, tag_commit,
                     e[EXP_W-1 -: REG_W], e[TAG_W +: DATA_W], e[TAG_W-1:0]);
          else pass_cnt++;
        end
      end
      if (clear) begin
        total_cnt++;
        if (exp_clr_q.size() == 0)
          $display("FAIL clear_unexpected: got clear=1 pc=%0h required clear=0", clear_pc);
        else begin
          pc = exp_clr_q.pop_front();
          if (clear_pc !== pc)
            $display("FAIL clear_pc: got %0h required %0h", clear_pc, pc);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; alloc_valid = 1'b0; cdb_valid = 1'b0; cdb_mispred = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic alloc(input logic [REG_W-1:0] dest);
    alloc_valid = 1'b1; alloc_dest = dest;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                     input logic mis, input logic [DATA_W-1:0] tgt);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data; cdb_mispred = mis; cdb_target = tgt;
    step();
    cdb_valid = 1'b0; cdb_mispred = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd7;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_mispred = 1'b0; cdb_target = '0;
    query_tag1 = '0; query_tag2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (alloc_tag !== 5'd1) $display("FAIL reset_alloc_tag: got %0d required 1", alloc_tag); else pass_cnt++;
    total_cnt++; if (rob_full !== 1'b0) $display("FAIL reset_full: got %0b required 0", rob_full); else pass_cnt++;
    total_cnt++; if (if_commit !== 1'b0) $display("FAIL reset_if_commit: got %0b required 0", if_commit); else pass_cnt++;
    total_cnt++; if (clear !== 1'b0) $display("FAIL reset_clear: got %0b required 0", clear); else pass_cnt++;
    total_cnt++;
    if ({pos_commit, data_commit, tag_commit, clear_pc} !== '0)
      $display("FAIL reset_outputs: got pos=%0h data=%0h tag=%0h pc=%0h required all 0",
               pos_commit, data_commit, tag_commit, clear_pc);
    else pass_cnt++;
    rst = 1'b1; alloc_valid = 1'b0;
    step();
    total_cnt++; if (alloc_tag !== 5'd1) $display("FAIL post_reset_alloc_tag: got %0d required 1", alloc_tag); else pass_cnt++;
  endtask

  task automatic test_in_order();
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    exp_q.push_back({5'd1, 32'h11, 5'd1});
    exp_q.push_back({5'd2, 32'h22, 5'd2});
    exp_q.push_back({5'd3, 32'h33, 5'd3});
    commit_edges.delete();
    cdb(5'd3, 32'h33, 1'b0, '0);
    cdb(5'd1, 32'h11, 1'b0, '0);
    cdb(5'd2, 32'h22, 1'b0, '0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    total_cnt++; if (exp_q.size() != 0) $display("FAIL in_order_drain: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    total_cnt++;
    if (commit_edges.size() != 3)
      $display("FAIL in_order_count: got %0d commits required 3", commit_edges.size());
    else if (commit_edges[1] != commit_edges[0] + 1 || commit_edges[2] != commit_edges[1] + 1)
      $display("FAIL in_order_consecutive: got edges %0d,%0d,%0d required consecutive",
               commit_edges[0], commit_edges[1], commit_edges[2]);
    else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) begin
      total_cnt++;
      if (alloc_tag !== TAG_W'(i + 1)) $display("FAIL fill_alloc_tag: got %0d required %0d", alloc_tag, i + 1); else pass_cnt++;
      alloc(REG_W'(i + 1));
    end
    total_cnt++; if (rob_full !== 1'b1) $display("FAIL full_flag: got %0b required 1", rob_full); else pass_cnt++;
    alloc(5'd31);
    total_cnt++; if (rob_full !== 1'b1) $display("FAIL full_after_ignored: got %0b required 1", rob_full); else pass_cnt++;
    total_cnt++; if (alloc_tag !== 5'd1) $display("FAIL full_alloc_tag: got %0d required 1", alloc_tag); else pass_cnt++;
    exp_q.push_back({5'd1, 32'h77, 5'd1});
    cdb(5'd1, 32'h77, 1'b0, '0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    total_cnt++; if (exp_q.size() != 0) $display("FAIL wrap_drain: got %0d pending required 0", exp_q.size()); else pass_cnt++;
    total_cnt++; if (rob_full !== 1'b0) $display("FAIL wrap_not_full: got %0b required 0", rob_full); else pass_cnt++;
    total_cnt++; if (alloc_tag !== 5'd1) $display("FAIL wrap_alloc_tag: got %0d required 1", alloc_tag); else pass_cnt++;
    alloc(5'd2);
    total_cnt++; if (alloc_tag !== 5'd2) $display("FAIL wrap_next_tag: got %0d required 2", alloc_tag); else pass_cnt++;
    total_cnt++; if (rob_full !== 1'b1) $display("FAIL wrap_refull: got %0b required 1", rob_full); else pass_cnt++;
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd5); alloc(5'd6); alloc(5'd7); alloc(5'd8);
    cdb(5'd3, 32'hC3, 1'b0, '0);
    cdb(5'd4, 32'hD4, 1'b0, '0);
    exp_q.push_back({5'd5, 32'hA1, 5'd1});
    cdb(5'd1, 32'hA1, 1'b0, '0);
    exp_q.push_back({5'd6, 32'hB2, 5'd2});
    exp_clr_q.push_back(32'h100);
    cdb(5'd2, 32'hB2, 1'b1, 32'h100);
    alloc(5'd9);
    total_cnt++; if (clear !== 1'b1) $display("FAIL mispred_clear: got %0b required 1", clear); else pass_cnt++;
    total_cnt++; if (alloc_tag !== 5'd1) $display("FAIL mispred_alloc_tag: got %0d required 1", alloc_tag); else pass_cnt++;
    total_cnt++; if (rob_full !== 1'b0) $display("FAIL mispred_full: got %0b required 0", rob_full); else pass_cnt++;
    step();
    total_cnt++; if (clear !== 1'b0) $display("FAIL mispred_clear_pulse: got %0b required 0", clear); else pass_cnt++;
    repeat (5) step();
    total_cnt++;
    if (exp_q.size() != 0 || exp_clr_q.size() != 0)
      $display("FAIL mispred_drain: got %0d/%0d pending required 0/0", exp_q.size(), exp_clr_q.size());
    else pass_cnt++;
  endtask

  task automatic test_rdy_stall();
    do_reset();
    alloc(5'd3); alloc(5'd4);
    exp_q.push_back({5'd3, 32'h55, 5'd1});
    exp_q.push_back({5'd4, 32'h66, 5'd2});
    cdb(5'd1, 32'h55, 1'b0, '0);
    cdb(5'd2, 32'h66, 1'b0, '0);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++;
      if (if_commit !== 1'b1 || pos_commit !== 5'd3 || tag_commit !== 5'd1 || alloc_tag !== 5'd3)
        $display("FAIL stall_hold: got commit=%0b pos=%0d tag=%0d alloc_tag=%0d required 1/3/1/3",
                 if_commit, pos_commit, tag_commit, alloc_tag);
      else pass_cnt++;
    end
    rdy = 1'b1;
    step();
    total_cnt++; if (pos_commit !== 5'd4) $display("FAIL stall_resume_pos: got %0d required 4", pos_commit); else pass_cnt++;
    step();
    total_cnt++; if (if_commit !== 1'b0) $display("FAIL stall_single: got %0b required 0", if_commit); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d pending required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(REG_W'(10 + i));
    query_tag1 = 5'd5; query_tag2 = 5'd0;
    #1;
    total_cnt++; if (query_ready1 !== 1'b0) $display("FAIL query_pending: got %0b required 0", query_ready1); else pass_cnt++;
    total_cnt++;
    if (query_ready2 !== 1'b1 || query_data2 !== '0)
      $display("FAIL query_tag0: got ready=%0b data=%0h required 1/0", query_ready2, query_data2);
    else pass_cnt++;
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'hAB; cdb_mispred = 1'b0;
    #1;
    total_cnt++;
    if (query_ready1 !== 1'b1 || query_data1 !== 32'hAB)
      $display("FAIL query_bypass: got ready=%0b data=%0h required 1/ab", query_ready1, query_data1);
    else pass_cnt++;
    step();
    cdb_valid = 1'b0; query_tag2 = 5'd6;
    #1;
    total_cnt++;
    if (query_ready1 !== 1'b1 || query_data1 !== 32'hAB)
      $display("FAIL query_stored: got ready=%0b data=%0h required 1/ab", query_ready1, query_data1);
    else pass_cnt++;
    total_cnt++; if (query_ready2 !== 1'b0) $display("FAIL query_invalid: got %0b required 0", query_ready2); else pass_cnt++;
    query_tag1 = '0; query_tag2 = '0;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_rdy_stall();
    test_query();
    repeat (3) step();
    total_cnt++;
    if (exp_q.size() != 0 || exp_clr_q.size() != 0)
      $display("FAIL final_scoreboard: got %0d/%0d pending required 0/0", exp_q.size(), exp_clr_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
